// File: rtl/buyruk_yukleyici_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package buyruk_yukleyici_pkg;
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_SHIFT     = 2;
endpackage

// File: rtl/kelime_birlestirici.sv
// Packs accepted bytes little-endian into a 32-bit word; word_done flags the fourth byte.
module kelime_birlestirici
    import buyruk_yukleyici_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take,
    input  logic [7:0]  data,
    output logic        word_done,
    output logic [31:0] word
);
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      lanes;

    assign word_done = take && (cnt == CNT_W'(BYTES_PER_WORD - 1));

    // Merge the byte being accepted so the complete word is visible on the same edge.
    always_comb begin
        word = lanes;
        word[{cnt, 3'b000} +: 8] = data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lanes <= '0;
        end else if (clr) begin
            cnt   <= '0;
            lanes <= '0;
        end else if (take) begin
            lanes[{cnt, 3'b000} +: 8] <= data;
            cnt                        <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/buyruk_yukleyici.sv
// Boot loader: streams bytes into instruction memory words and holds the core until done.
// Optional trailing XOR checksum byte enabled by BUYRUK_YUKLEYICI_CHECKSUM_EN.
module buyruk_yukleyici
    import buyruk_yukleyici_pkg::*;
#(
    parameter int WORD_COUNT = 16,
    parameter int IDX_W      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        cpu_hold_o
);
    state_t           state, state_n;
    logic [IDX_W-1:0] idx;
    logic             accept, recv_accept, clr, last_word, word_done, error_n;
    logic [31:0]      word;

    assign accept      = byte_valid_i && byte_ready_o;
    assign recv_accept = accept && (state == RECV);
    assign clr         = start_i && ((state == IDLE) || (state == DONE));
    assign last_word   = (idx == IDX_W'(WORD_COUNT - 1));

    kelime_birlestirici u_birlestirici (
        .clk       (clk_i),
        .rst       (rst_i),
        .clr       (clr),
        .take      (recv_accept),
        .data      (byte_data_i),
        .word_done (word_done),
        .word      (word)
    );

`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
    logic [7:0] csum;
`endif

    always_comb begin
        state_n = state;
`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
        error_n = error_o;
`else
        error_n = 1'b0;
`endif
        case (state)
            IDLE, DONE: if (start_i) begin
                state_n = RECV;
                error_n = 1'b0;
            end
            RECV: if (recv_accept && word_done) state_n = WRITE;
            WRITE: begin
`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
                state_n = last_word ? CHECK : RECV;
`else
                state_n = last_word ? DONE : RECV;
`endif
            end
`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
            CHECK: if (accept) begin
                state_n = DONE;
                error_n = (byte_data_i != csum);
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            idx          <= '0;
            byte_ready_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            cpu_hold_o   <= 1'b1;
        end else begin
            state        <= state_n;
            byte_ready_o <= (state_n == RECV) || (state_n == CHECK);
            mem_we_o     <= (state_n == WRITE);
            busy_o       <= (state_n == RECV) || (state_n == WRITE) || (state_n == CHECK);
            done_o       <= (state_n == DONE);
            cpu_hold_o   <= !((state_n == DONE) && !error_n);
            if (clr)
                idx <= '0;
            else if ((state == WRITE) && !last_word)
                idx <= idx + 1'b1;
            if (recv_accept && word_done) begin
                mem_addr_o <= 32'(idx) << WORD_SHIFT;
                mem_data_o <= word;
            end
        end
    end

`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_o <= 1'b0;
            csum    <= '0;
        end else begin
            error_o <= error_n;
            if (clr)
                csum <= '0;
            else if (recv_accept)
                csum <= csum ^ byte_data_i;
        end
    end
`else
    assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_buyruk_yukleyici.sv
// Directed bench for buyruk_yukleyici; honours BUYRUK_YUKLEYICI_CHECKSUM_EN when defined.
module tb_buyruk_yukleyici;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, mem_we, busy, done, error, cpu_hold;
    logic [31:0] mem_addr, mem_data;

    int checks = 0;
    int failures = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [31:0] words[16];

    buyruk_yukleyici #(.WORD_COUNT(16), .IDX_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .byte_valid_i (byte_valid),
        .byte_data_i  (byte_data),
        .byte_ready_o (byte_ready),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .cpu_hold_o   (cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the accepting edge, valid left high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_data  = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(n), 32'(0));
        @(negedge clk);
    endtask

    task automatic pulse_start();
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < 30), 32'(1));
    endtask

    task automatic check_image(input string tag);
        chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'(16));
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, wr_addr[i], 32'(i * 4));
            chk({tag, "_data"}, wr_data[i], words[i]);
        end
    endtask

    // Full image from the current state; start_at >= 0 pulses start before that byte.
    task automatic load_image(input bit bad_csum, input int start_at);
        logic [7:0] csum = 8'h00;
        logic [7:0] b;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        chk("load_busy", 32'(busy), 32'(1));
        chk("load_hold", 32'(cpu_hold), 32'(1));
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 4; j++) begin
                if (k * 4 + j == start_at) pulse_start();
                b = words[k][j*8 +: 8];
                csum ^= b;
                send_byte(b);
            end
`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
        send_byte(bad_csum ? ~csum : csum);
`else
        if (bad_csum) chk("no_csum_build", 32'(bad_csum), 32'(0));
`endif
        byte_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) words[k] = 32'h00000013 + 32'(k) * 32'h00100080;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'(0));
        chk("rst_we", 32'(mem_we), 32'(0));
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_data", mem_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_error", 32'(error), 32'(0));
        chk("rst_hold", 32'(cpu_hold), 32'(1));
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_nwr", 32'(wr_addr.size()), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_hold", 32'(cpu_hold), 32'(1));

        // Full load, valid held high
        load_image(1'b0, -1);
        check_image("full");
        chk("full_done", 32'(done), 32'(1));
        chk("full_hold", 32'(cpu_hold), 32'(0));
        chk("full_error", 32'(error), 32'(0));
        chk("full_busy", 32'(busy), 32'(0));

        // Restart from DONE, then backpressure with gaps
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        chk("restart_done", 32'(done), 32'(0));
        chk("restart_hold", 32'(cpu_hold), 32'(1));
        chk("restart_busy", 32'(busy), 32'(1));
        begin
            logic [31:0] bp;
            bp = 32'hEFBEADDE;
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    byte_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                end
                send_byte(bp[j*8 +: 8]);
            end
        end
        chk("bp_we_n1", 32'(mem_we), 32'(1));
        chk("bp_ready_n1", 32'(byte_ready), 32'(0));
        chk("bp_addr", mem_addr, 32'h0);
        chk("bp_data", mem_data, 32'hEFBEADDE);
        byte_data = 8'h11;
        @(negedge clk);
        chk("bp_we_n2", 32'(mem_we), 32'(0));
        chk("bp_ready_n2", 32'(byte_ready), 32'(1));
        @(negedge clk);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bp_nwr", 32'(wr_addr.size()), 32'(2));
        if (wr_addr.size() >= 2) begin
            chk("bp_w0", wr_data[0], 32'hEFBEADDE);
            chk("bp_a1", wr_addr[1], 32'h4);
            chk("bp_w1", wr_data[1], 32'h44332211);
        end

        // Reset mid-load after 6 bytes
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(words[i/4][(i%4)*8 +: 8]);
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_ready", 32'(byte_ready), 32'(0));
        chk("mid_hold", 32'(cpu_hold), 32'(1));
        chk("mid_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        byte_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_nwr", 32'(wr_addr.size()), 32'(1));
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        for (int j = 0; j < 4; j++) send_byte(words[0][j*8 +: 8]);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("fresh_nwr", 32'(wr_addr.size()), 32'(1));
        if (wr_addr.size() >= 1) begin
            chk("fresh_addr", wr_addr[0], 32'h0);
            chk("fresh_data", wr_data[0], words[0]);
        end

        // start while busy, from a clean idle
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_image(1'b0, 10);
        check_image("sbusy");
        chk("sbusy_hold", 32'(cpu_hold), 32'(0));

`ifdef BUYRUK_YUKLEYICI_CHECKSUM_EN
        load_image(1'b1, -1);
        check_image("bad");
        chk("bad_error", 32'(error), 32'(1));
        chk("bad_done", 32'(done), 32'(1));
        chk("bad_hold", 32'(cpu_hold), 32'(1));
        load_image(1'b0, -1);
        chk("good_error", 32'(error), 32'(0));
        chk("good_hold", 32'(cpu_hold), 32'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
